// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: load-type encodings,
// default widths and the load misalignment rule.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_REG_AW = 5;

  typedef enum logic [2:0] {
    LT_LB  = 3'd0,
    LT_LH  = 3'd1,
    LT_LW  = 3'd2,
    LT_LBU = 3'd4,
    LT_LHU = 3'd5
  } load_type_e;

  // Halfwords need an even address, words need a word-aligned address.
  function automatic logic load_misaligned(input logic [2:0] load_type,
                                           input logic [1:0] addr_low);
    logic mis;
    mis = 1'b0;
    if ((load_type == LT_LH) || (load_type == LT_LHU))
      mis = addr_low[0];
    else if (load_type == LT_LW)
      mis = (addr_low != 2'd0);
    return mis;
  endfunction

endpackage

// File: rtl/wb_load_align.sv
// Combinational little-endian load lane select with sign/zero extension.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W
) (
  input  logic        [DATA_W-1:0] mem_data,
  input  logic        [1:0]        addr_low,
  input  logic        [2:0]        load_type,
  output logic signed [DATA_W-1:0] ext_data,
  output logic                     misaligned
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s     = mem_data[8*addr_low +: 8];
    half_s     = addr_low[1] ? mem_data[31:16] : mem_data[15:0];
    misaligned = load_misaligned(load_type, addr_low);
    case (load_type)
      LT_LB:   ext_data = {{(DATA_W-8){byte_s[7]}}, byte_s};
      LT_LBU:  ext_data = {{(DATA_W-8){1'b0}}, byte_s};
      LT_LH:   ext_data = {{(DATA_W-16){half_s[15]}}, half_s};
      LT_LHU:  ext_data = {{(DATA_W-16){1'b0}}, half_s};
      default: ext_data = mem_data;
    endcase
  end

endmodule

// File: rtl/wb_writeback.sv
// Writeback stage: MEM/WB register, load/ALU result select, register-bank
// write port, forwarding tap and retired-instruction counter.
module wb_writeback
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_AW = WB_REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_regWrite,
  input  logic              in_memToReg,
  input  logic [2:0]        in_loadType,
  input  logic [1:0]        in_addrLow,
  input  logic [DATA_W-1:0] in_aluResult,
  input  logic [DATA_W-1:0] in_memData,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              stall,
  input  logic              flush,
  output logic [REG_AW-1:0] destinoDoescreverData,
  output logic [DATA_W-1:0] wdataValor,
  output logic              VaiEscrever,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  retired_count
);

  logic                     vld_p0, done_p0;
  logic                     regwrite_p0, memtoreg_p0;
  logic        [2:0]        loadtype_p0;
  logic        [1:0]        addrlow_p0;
  logic signed [DATA_W-1:0] alu_p0;
  logic        [DATA_W-1:0] memdata_p0;
  logic        [REG_AW-1:0] rd_p0;
  logic        [CNT_W-1:0]  cnt_q;

  logic signed [DATA_W-1:0] load_data, res;
  logic                     lane_mis, mis, first, writes;

  // MEM/WB register; done marks an entry whose write already happened
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0      <= 1'b0;
      done_p0     <= 1'b0;
      regwrite_p0 <= 1'b0;
      memtoreg_p0 <= 1'b0;
      loadtype_p0 <= '0;
      addrlow_p0  <= '0;
      alu_p0      <= '0;
      memdata_p0  <= '0;
      rd_p0       <= '0;
    end else if (flush) begin
      vld_p0  <= 1'b0;
      done_p0 <= 1'b0;
    end else if (stall) begin
      done_p0 <= done_p0 | vld_p0;
    end else begin
      vld_p0      <= in_valid;
      done_p0     <= 1'b0;
      regwrite_p0 <= in_regWrite;
      memtoreg_p0 <= in_memToReg;
      loadtype_p0 <= in_loadType;
      addrlow_p0  <= in_addrLow;
      alu_p0      <= in_aluResult;
      memdata_p0  <= in_memData;
      rd_p0       <= in_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else if (first)
      cnt_q <= cnt_q + 1'b1;
  end

  wb_load_align #(.DATA_W(DATA_W)) u_align (
    .mem_data   (memdata_p0),
    .addr_low   (addrlow_p0),
    .load_type  (loadtype_p0),
    .ext_data   (load_data),
    .misaligned (lane_mis)
  );

  always_comb begin
    mis    = memtoreg_p0 & lane_mis;
    res    = memtoreg_p0 ? load_data : alu_p0;
    first  = vld_p0 & ~done_p0;
    writes = vld_p0 & regwrite_p0 & (rd_p0 != '0) & ~mis;

    destinoDoescreverData = vld_p0 ? rd_p0 : '0;
    wdataValor            = vld_p0 ? res : '0;
    VaiEscrever           = writes & ~done_p0;
    fwd_valid             = writes;
    fwd_rd                = rd_p0;
    fwd_data              = res;
    misalign_err          = first & mis;
    retired_count         = cnt_q;
  end

endmodule

// File: tb/tb_wb_writeback.sv
// Directed bench for wb_writeback; a second instance with a 3-bit counter
// exercises counter wrap-around.
module tb_wb_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_regWrite, in_memToReg;
  logic [2:0]  in_loadType;
  logic [1:0]  in_addrLow;
  logic [31:0] in_aluResult, in_memData;
  logic [4:0]  in_rd;
  logic        stall, flush;

  logic [4:0]  dest, frd;
  logic [31:0] wdata, fdata;
  logic        we, fv, mis;
  logic [31:0] cnt;

  logic [4:0]  w_dest, w_frd;
  logic [31:0] w_wdata, w_fdata;
  logic        w_we, w_fv, w_mis;
  logic [2:0]  w_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_writeback dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_regWrite(in_regWrite),
    .in_memToReg(in_memToReg), .in_loadType(in_loadType), .in_addrLow(in_addrLow),
    .in_aluResult(in_aluResult), .in_memData(in_memData), .in_rd(in_rd),
    .stall(stall), .flush(flush), .destinoDoescreverData(dest), .wdataValor(wdata),
    .VaiEscrever(we), .fwd_valid(fv), .fwd_rd(frd), .fwd_data(fdata),
    .misalign_err(mis), .retired_count(cnt)
  );

  wb_writeback #(.CNT_W(3)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_regWrite(in_regWrite),
    .in_memToReg(in_memToReg), .in_loadType(in_loadType), .in_addrLow(in_addrLow),
    .in_aluResult(in_aluResult), .in_memData(in_memData), .in_rd(in_rd),
    .stall(stall), .flush(flush), .destinoDoescreverData(w_dest), .wdataValor(w_wdata),
    .VaiEscrever(w_we), .fwd_valid(w_fv), .fwd_rd(w_frd), .fwd_data(w_fdata),
    .misalign_err(w_mis), .retired_count(w_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [2:0] lt, input logic [1:0] al,
                       input logic [31:0] alu, input logic [31:0] md,
                       input logic [4:0] rd);
    in_valid = v; in_regWrite = rw; in_memToReg = m2r; in_loadType = lt;
    in_addrLow = al; in_aluResult = alu; in_memData = md; in_rd = rd;
  endtask

  task automatic idle;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    idle();
    tick(); tick();
    chk("rst_dest", 32'(dest), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_fv", 32'(fv), 32'd0);
    chk("rst_frd", 32'(frd), 32'd0);
    chk("rst_fdata", fdata, 32'd0);
    chk("rst_mis", 32'(mis), 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    reset = 1'b0;
    tick();

    // ALU write to r5
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_1234, 32'h0, 5'd5);
    tick();
    chk("alu_we", 32'(we), 32'd1);
    chk("alu_dest", 32'(dest), 32'd5);
    chk("alu_wdata", wdata, 32'h0000_1234);
    chk("alu_fv", 32'(fv), 32'd1);
    chk("alu_cnt_before", cnt, 32'd0);
    idle(); tick();
    chk("alu_cnt", cnt, 32'd1);
    chk("idle_we", 32'(we), 32'd0);
    chk("idle_dest", 32'(dest), 32'd0);

    // write to x0 suppressed but still retires
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 5'd0);
    tick();
    chk("x0_we", 32'(we), 32'd0);
    chk("x0_fv", 32'(fv), 32'd0);
    idle(); tick();
    chk("x0_cnt", cnt, 32'd2);

    // loads back-to-back, memData = 80FF_7F01
    drive(1'b1, 1'b1, 1'b1, 3'd0, 2'd3, 32'h55, 32'h80FF_7F01, 5'd3);
    tick();
    chk("lb3", wdata, 32'hFFFF_FF80);
    chk("lb3_we", 32'(we), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 3'd4, 2'd3, 32'h55, 32'h80FF_7F01, 5'd3);
    tick();
    chk("lbu3", wdata, 32'h0000_0080);
    drive(1'b1, 1'b1, 1'b1, 3'd1, 2'd2, 32'h55, 32'h80FF_7F01, 5'd3);
    tick();
    chk("lh2", wdata, 32'hFFFF_80FF);
    drive(1'b1, 1'b1, 1'b1, 3'd5, 2'd0, 32'h55, 32'h80FF_7F01, 5'd3);
    tick();
    chk("lhu0", wdata, 32'h0000_7F01);
    drive(1'b1, 1'b1, 1'b1, 3'd2, 2'd0, 32'h55, 32'h80FF_7F01, 5'd3);
    tick();
    chk("lw0", wdata, 32'h80FF_7F01);
    chk("lw0_mis", 32'(mis), 32'd0);
    idle(); tick();
    chk("load_cnt", cnt, 32'd7);

    // misaligned LW
    drive(1'b1, 1'b1, 1'b1, 3'd2, 2'd2, 32'h0, 32'h1111_2222, 5'd7);
    tick();
    chk("mis_pulse", 32'(mis), 32'd1);
    chk("mis_we", 32'(we), 32'd0);
    chk("mis_fv", 32'(fv), 32'd0);
    chk("mis_dest", 32'(dest), 32'd7);
    idle(); tick();
    chk("mis_end", 32'(mis), 32'd0);
    chk("mis_cnt", cnt, 32'd8);

    // 3-cycle stall on ALU write to r9
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_ABCD, 32'h0, 5'd9);
    tick();
    chk("st1_we", 32'(we), 32'd1);
    chk("st1_fv", 32'(fv), 32'd1);
    stall = 1'b1; idle();
    tick();
    chk("st2_we", 32'(we), 32'd0);
    chk("st2_fv", 32'(fv), 32'd1);
    chk("st2_dest", 32'(dest), 32'd9);
    chk("st2_wdata", wdata, 32'h0000_ABCD);
    tick();
    chk("st3_we", 32'(we), 32'd0);
    chk("st3_fv", 32'(fv), 32'd1);
    chk("st3_cnt", cnt, 32'd9);
    stall = 1'b0;
    tick();
    chk("st_end_fv", 32'(fv), 32'd0);
    chk("st_cnt", cnt, 32'd9);

    // flush wins over stall
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h77, 32'h0, 5'd10);
    tick();
    chk("fl_pre_we", 32'(we), 32'd1);
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h88, 32'h0, 5'd11);
    tick();
    chk("fl_we", 32'(we), 32'd0);
    chk("fl_fv", 32'(fv), 32'd0);
    chk("fl_dest", 32'(dest), 32'd0);
    tick();
    chk("fl_we2", 32'(we), 32'd0);
    chk("fl_cnt", cnt, 32'd10);
    stall = 1'b0; flush = 1'b0;

    // reset during a stall
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h99, 32'h0, 5'd12);
    tick();
    stall = 1'b1; idle();
    tick();
    chk("rs_hold_fv", 32'(fv), 32'd1);
    reset = 1'b1;
    tick();
    chk("rs_we", 32'(we), 32'd0);
    chk("rs_fv", 32'(fv), 32'd0);
    chk("rs_dest", 32'(dest), 32'd0);
    chk("rs_frd", 32'(frd), 32'd0);
    chk("rs_cnt", cnt, 32'd0);
    reset = 1'b0; stall = 1'b0;
    tick();
    chk("rs_after_we", 32'(we), 32'd0);

    // counter wrap on the 3-bit instance
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'(i), 32'h0, 5'd1);
      tick();
    end
    chk("wrap_pre", 32'(w_cnt), 32'd7);
    idle(); tick();
    chk("wrap_zero", 32'(w_cnt), 32'd0);
    chk("wrap_main", cnt, 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
